branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Branch/jump resolution block of the decode stage. Selects the branch base (PC or rs1 value), adds the decoded immediate with a 32-bit adder, and decodes funct3 with a 3-to-8 active-low decoder against the execute-stage comparison flags. It registers the target address and an active-low taken flag for the fetch stage.

## Interface
Parameters:
- none

Ports:
- clk  input  1  sole clock; all state updates on the falling edge
- rst  input  1  reset, asynchronous, active-high
- en_n  input  1  register load enable, active low; high = hold
- pc  input  32  PC of the instruction in decode
- qa  input  32  rs1 read data
- imm  input  32  sign-extended immediate (B-, J- or I-type, selected upstream)
- funct3  input  3  inst[14:12]
- branch_n  input  1  conditional-branch opcode, active low
- jal_n  input  1  JAL opcode, active low
- jalr_n  input  1  JALR opcode, active low
- is_zero  input  1  rs1 == rs2, active low
- is_lt  input  1  signed rs1 < rs2, active low
- is_ltu  input  1  unsigned rs1 < rs2, active low
- brh  output  32→1  registered taken flag, active low (1 bit)
- brh_addr  output  32  registered branch/jump target

## Operation
- Decoder: dec[7:0] = 3-to-8 active-low decode of funct3, enabled only when branch_n = 0; all ones otherwise.
- Taken flag, active low, combinational: flag = jal_n & jalr_n & (dec[0]|is_zero) & (dec[1]|~is_zero) & (dec[4]|is_lt) & (dec[5]|~is_lt) & (dec[6]|is_ltu) & (dec[7]|~is_ltu).
  - beq taken on is_zero=0; bne taken on is_zero=1.
  - blt taken on is_lt=0; bge taken on is_lt=1.
  - bltu taken on is_ltu=0; bgeu taken on is_ltu=1.
  - funct3 010/011 never taken.
  - jal_n=0 or jalr_n=0 always taken.
- Base: qa when jalr_n = 0, else pc.
- Target: sum = base + imm, modulo 2^32; carry discarded, no overflow detection.
- With BRH_LSB_CLEAR_EN defined, the registered target is {sum[31:1],1'b0}.
- If several opcode strobes are low at once, any low jal_n/jalr_n forces taken, and jalr_n alone selects the base.

## Timing
- Target path and flag path are purely combinational up to the output register. Latency is one falling edge of clk.
- Output register (74x377-style):
  - On the falling edge of clk with en_n = 0: brh ← flag, brh_addr ← target.
  - With en_n = 1: both outputs hold.
- Reset:
  - rst = 1 asynchronously forces brh = 1 (not taken) and brh_addr = 0, independent of clk and en_n.
  - While rst is high, falling edges are ignored.
  - On rst deassertion, the first falling edge with en_n = 0 loads normally.
  - Reset asserted mid-cycle immediately discards any pending or registered taken state.
- Outputs change only on a falling edge or on reset assertion. They are glitch-free between edges.

## Configuration
- BRH_LSB_CLEAR_EN defined: bit 0 of the registered target is forced to 0 for all target types (JALR alignment rule).
- Not defined: brh_addr = full 32-bit sum including bit 0.

## Test plan
- Reset: assert rst with arbitrary inputs → brh=1, brh_addr=0x00000000 immediately. Values hold across falling edges until rst=0.
- BEQ taken: branch_n=0, funct3=000, is_zero=0, pc=0x100, imm=0xFFFFFFF0, en_n=0, falling edge → brh=0, brh_addr=0x000000F0.
- BNE not taken: branch_n=0, funct3=001, is_zero=0 → brh=1. BGEU with is_ltu=1 → brh=0. funct3=011 with any flags → brh=1.
- JALR: jalr_n=0, qa=0x00001003, imm=0x00000004, pc=0x200:
  - with BRH_LSB_CLEAR_EN → brh=0, brh_addr=0x00001006;
  - without → brh_addr=0x00001007.
- Wrap and hold: jal_n=0, pc=0xFFFFFFFC, imm=0x8 → brh_addr=0x00000004, brh=0. Then set en_n=1, change all inputs, apply 3 falling edges → outputs unchanged.
- No-branch: all strobes high, is_* arbitrary → brh=1 after the edge.

Source files
------------

// File: rtl/branch_resolve_if.sv
// Decode-stage branch resolution bus: opcode strobes, operands and compare flags in, registered taken flag and target out.
// Strobes are level-qualified by en_n only; there is no valid/ready handshake on this bus.
interface branch_resolve_if;
  logic        en_n;
  logic [31:0] pc;
  logic [31:0] qa;
  logic [31:0] imm;
  logic [2:0]  funct3;
  logic        branch_n;
  logic        jal_n;
  logic        jalr_n;
  logic        is_zero;
  logic        is_lt;
  logic        is_ltu;
  logic        brh;
  logic [31:0] brh_addr;

  modport master (
    output en_n, pc, qa, imm, funct3, branch_n, jal_n, jalr_n,
           is_zero, is_lt, is_ltu,
    input  brh, brh_addr
  );

  modport slave (
    input  en_n, pc, qa, imm, funct3, branch_n, jal_n, jalr_n,
           is_zero, is_lt, is_ltu,
    output brh, brh_addr
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution: base+imm target adder, active-low funct3 decode vs compare flags, falling-edge output register.
// Optional macro BRH_LSB_CLEAR_EN forces bit 0 of the registered target to zero.
module branch_resolve_unit (
  input  logic              clk,
  input  logic              rst,
  branch_resolve_if.slave   bus
);

  logic [7:0]  dec;
  logic        flag;
  logic [31:0] base;
  logic [31:0] sum;
  logic [31:0] target;
  logic        unused_dec;

  // Active-low 3-to-8 decode, only live for conditional-branch opcodes.
  always_comb begin
    dec = 8'hFF;
    if (!bus.branch_n) dec[bus.funct3] = 1'b0;
  end

  // funct3 010/011 have no compare term, so those decodes never pull the flag low.
  assign unused_dec = ^dec[3:2];

  assign flag = bus.jal_n & bus.jalr_n
              & (dec[0] |  bus.is_zero) & (dec[1] | ~bus.is_zero)
              & (dec[4] |  bus.is_lt)   & (dec[5] | ~bus.is_lt)
              & (dec[6] |  bus.is_ltu)  & (dec[7] | ~bus.is_ltu);

  assign base = bus.jalr_n ? bus.pc : bus.qa;
  assign sum  = base + bus.imm;

`ifdef BRH_LSB_CLEAR_EN
  assign target = {sum[31:1], 1'b0};
`else
  assign target = sum;
`endif

  // 74x377-style register: loads on the falling edge when en_n is low.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      bus.brh      <= 1'b1;
      bus.brh_addr <= 32'h0000_0000;
    end else if (!bus.en_n) begin
      bus.brh      <= flag;
      bus.brh_addr <= target;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed literal cases plus randomized traffic against a behavioural model.
module tb_branch_resolve_unit;

  logic clk;
  logic rst;
  logic check_en;
  int   n_tests;
  int   n_fail;

  logic        m_brh;
  logic [31:0] m_addr;
  logic [32:0] exp_q[$];

  branch_resolve_if bus ();

  branch_resolve_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  function automatic logic model_brh(input logic br_n, input logic j_n, input logic jr_n,
                                     input logic [2:0] f3, input logic z, input logic lt,
                                     input logic ltu);
    logic taken;
    taken = 1'b0;
    if (!j_n || !jr_n) taken = 1'b1;
    else if (!br_n) begin
      case (f3)
        3'd0:    taken = (z == 1'b0);
        3'd1:    taken = (z == 1'b1);
        3'd4:    taken = (lt == 1'b0);
        3'd5:    taken = (lt == 1'b1);
        3'd6:    taken = (ltu == 1'b0);
        3'd7:    taken = (ltu == 1'b1);
        default: taken = 1'b0;
      endcase
    end
    return !taken;
  endfunction

  function automatic logic [31:0] model_addr(input logic jr_n, input logic [31:0] p,
                                             input logic [31:0] a, input logic [31:0] i);
    logic [31:0] s;
    s = (jr_n ? p : a) + i;
`ifdef BRH_LSB_CLEAR_EN
    s[0] = 1'b0;
`endif
    return s;
  endfunction

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_brh  = 1'b1;
      m_addr = 32'h0;
    end else if (!bus.en_n) begin
      m_brh  = model_brh(bus.branch_n, bus.jal_n, bus.jalr_n, bus.funct3,
                         bus.is_zero, bus.is_lt, bus.is_ltu);
      m_addr = model_addr(bus.jalr_n, bus.pc, bus.qa, bus.imm);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got brh=%0b addr=%08h, required brh=%0b addr=%08h",
               name, act[32], act[31:0], req[32], req[31:0]);
    end
  endtask

  // Pins both the DUT and the model against a hand-computed value.
  task automatic expect_lit(input string name, input logic b, input logic [31:0] a);
    logic [32:0] e;
    exp_q.push_back({b, a});
    e = exp_q.pop_front();
    check(name, {bus.brh, bus.brh_addr}, e);
    check({name, "_model"}, {m_brh, m_addr}, e);
  endtask

  always @(posedge clk) begin
    if (check_en) check("cycle", {bus.brh, bus.brh_addr}, {m_brh, m_addr});
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic en, input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] i, input logic [2:0] f3, input logic br,
                        input logic j, input logic jr, input logic z, input logic lt,
                        input logic ltu);
    bus.en_n = en;  bus.pc = p;  bus.qa = a;  bus.imm = i;  bus.funct3 = f3;
    bus.branch_n = br;  bus.jal_n = j;  bus.jalr_n = jr;
    bus.is_zero = z;  bus.is_lt = lt;  bus.is_ltu = ltu;
  endtask

  task automatic randomize_in(input logic en);
    set_in(en, $urandom, $urandom, $urandom, 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic drive_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic at_posedge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_tests  = 0;
    n_fail   = 0;
    check_en = 1'b0;
    rst      = 1'b1;
    randomize_in(1'b0);
    #2;
    expect_lit("reset_async", 1'b1, 32'h0);
    for (int k = 0; k < 2; k++) begin
      drive_edge();
      expect_lit("reset_hold", 1'b1, 32'h0);
    end
    at_posedge();
    rst      = 1'b0;
    check_en = 1'b1;

    set_in(1'b0, 32'h100, 32'h0, 32'hFFFF_FFF0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    drive_edge();
    expect_lit("beq_taken", 1'b0, 32'h0000_00F0);

    at_posedge();
    bus.funct3 = 3'b001;
    bus.is_zero = 1'b0;
    drive_edge();
    expect_lit("bne_not_taken", 1'b1, 32'h0000_00F0);

    at_posedge();
    bus.funct3 = 3'b111;
    bus.is_ltu = 1'b1;
    drive_edge();
    expect_lit("bgeu_taken", 1'b0, 32'h0000_00F0);

    for (int k = 0; k < 4; k++) begin
      at_posedge();
      bus.funct3 = 3'b011;
      bus.is_zero = 1'(k);
      bus.is_lt = 1'(k >> 1);
      bus.is_ltu = ~1'(k);
      drive_edge();
      expect_lit("f3_011_never", 1'b1, 32'h0000_00F0);
    end

    at_posedge();
    set_in(1'b0, 32'h200, 32'h0000_1003, 32'h4, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    drive_edge();
`ifdef BRH_LSB_CLEAR_EN
    expect_lit("jalr_target", 1'b0, 32'h0000_1006);
`else
    expect_lit("jalr_target", 1'b0, 32'h0000_1007);
`endif

    at_posedge();
    set_in(1'b0, 32'hFFFF_FFFC, 32'h1234_5678, 32'h8, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    drive_edge();
    expect_lit("jal_wrap", 1'b0, 32'h0000_0004);

    at_posedge();
    randomize_in(1'b1);
    for (int k = 0; k < 3; k++) begin
      drive_edge();
      expect_lit("hold_en_n", 1'b0, 32'h0000_0004);
      at_posedge();
      randomize_in(1'b1);
    end

    set_in(1'b0, 32'h40, 32'hDEAD_BEEF, 32'h10, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_edge();
    expect_lit("no_branch", 1'b1, 32'h0000_0050);

    at_posedge();
    set_in(1'b0, 32'h1000, 32'h0, 32'h20, 3'b100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_edge();
    expect_lit("blt_taken", 1'b0, 32'h0000_1020);
    #2;
    rst = 1'b1;
    #1;
    expect_lit("reset_midcycle", 1'b1, 32'h0);
    #1;
    rst = 1'b0;

    for (int n = 0; n < 500; n++) begin
      at_posedge();
      randomize_in(($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 39) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        check("rand_reset", {bus.brh, bus.brh_addr}, 33'h1_0000_0000);
        rst = 1'b0;
      end
    end

    at_posedge();
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
